// File: rtl/fft_frame_ctrl.sv
// Frame sequencer feeding the fft core sink port: frames an untimed sample stream,
// zero-pads short frames, limits frames in flight with source-side eop credits and flags errors.
module fft_frame_ctrl #(
    parameter int MIN_PTS         = 64,
    parameter int MAX_PTS         = 1024,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] in_real,
    input  logic [13:0] in_imag,
    input  logic        in_last,
    input  logic [10:0] cfg_points,
    input  logic        cfg_inverse,
    input  logic        err_clr,
    output logic        sink_valid,
    input  logic        sink_ready,
    output logic        sink_sop,
    output logic        sink_eop,
    output logic [13:0] sink_real,
    output logic [13:0] sink_imag,
    output logic [1:0]  sink_error,
    output logic [10:0] fftpts_in,
    output logic        inverse,
    input  logic        source_valid,
    input  logic        source_ready,
    input  logic        source_eop,
    input  logic [1:0]  source_error,
    output logic        busy,
    output logic        cfg_err,
    output logic        core_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAD = 2'd2} state_t;

    localparam logic [10:0] MIN_PTS_C  = 11'(MIN_PTS);
    localparam logic [10:0] MAX_PTS_C  = 11'(MAX_PTS);
    localparam logic [2:0]  MAX_OUT_C  = 3'(MAX_OUTSTANDING);

    function automatic logic pts_legal(input logic [10:0] pts);
        logic pow2;
        pow2 = (pts != 11'd0) && ((pts & (pts - 11'd1)) == 11'd0);
        return pow2 && (pts >= MIN_PTS_C) && (pts <= MAX_PTS_C);
    endfunction

    state_t      state_r, state_nxt_s;
    logic [10:0] cnt_r, cnt_nxt_s;
    logic [2:0]  outstanding_r;
    logic        sink_valid_r, sink_sop_r, sink_eop_r;
    logic [13:0] sink_real_r, sink_imag_r;
    logic [10:0] fftpts_r;
    logic        inverse_r, cfg_err_r, core_err_r;

    logic        slot_free_s, cfg_ok_s, at_last_s, credit_ok_s, eop_hs_s, src_eop_s;
    logic        in_ready_s, load_s, load_sop_s, load_eop_s, latch_cfg_s, cfg_bad_s;
    logic [13:0] load_real_s, load_imag_s;

    assign slot_free_s = ~sink_valid_r | sink_ready;
    assign cfg_ok_s    = pts_legal(cfg_points);
    assign at_last_s   = (cnt_r == (fftpts_r - 11'd1));
    assign credit_ok_s = (outstanding_r < MAX_OUT_C);
    assign eop_hs_s    = sink_valid_r & sink_ready & sink_eop_r;
    assign src_eop_s   = source_valid & source_ready & source_eop;

    // Next-state, acceptance and sink-slot load decisions for the frame sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        in_ready_s  = 1'b0;
        load_s      = 1'b0;
        load_sop_s  = 1'b0;
        load_eop_s  = 1'b0;
        load_real_s = 14'd0;
        load_imag_s = 14'd0;
        latch_cfg_s = 1'b0;
        cfg_bad_s   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = slot_free_s & cfg_ok_s & credit_ok_s;
                if (in_valid & ~cfg_ok_s) begin
                    cfg_bad_s = 1'b1;
                end else begin
                    cfg_bad_s = 1'b0;
                end
                if (in_valid & in_ready_s) begin
                    load_s      = 1'b1;
                    load_sop_s  = 1'b1;
                    load_real_s = in_real;
                    load_imag_s = in_imag;
                    latch_cfg_s = 1'b1;
                    cnt_nxt_s   = 11'd1;
                    state_nxt_s = in_last ? PAD : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                in_ready_s = slot_free_s;
                if (in_valid & slot_free_s) begin
                    load_s      = 1'b1;
                    load_eop_s  = at_last_s;
                    load_real_s = in_real;
                    load_imag_s = in_imag;
                    // The final slot always closes the frame, even if in_last arrives with it.
                    if (at_last_s) begin
                        cnt_nxt_s   = 11'd0;
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s   = cnt_r + 11'd1;
                        state_nxt_s = in_last ? PAD : RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PAD: begin
                if (slot_free_s) begin
                    load_s     = 1'b1;
                    load_eop_s = at_last_s;
                    if (at_last_s) begin
                        cnt_nxt_s   = 11'd0;
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s   = cnt_r + 11'd1;
                        state_nxt_s = PAD;
                    end
                end else begin
                    state_nxt_s = PAD;
                end
            end
            default: begin
                cnt_nxt_s   = 11'd0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and sample-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 11'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Sink output slot: loaded when free, held while the core stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            sink_valid_r <= 1'b0;
            sink_sop_r   <= 1'b0;
            sink_eop_r   <= 1'b0;
            sink_real_r  <= 14'd0;
            sink_imag_r  <= 14'd0;
        end else if (load_s) begin
            sink_valid_r <= 1'b1;
            sink_sop_r   <= load_sop_s;
            sink_eop_r   <= load_eop_s;
            sink_real_r  <= load_real_s;
            sink_imag_r  <= load_imag_s;
        end else if (sink_ready) begin
            sink_valid_r <= 1'b0;
            sink_sop_r   <= 1'b0;
            sink_eop_r   <= 1'b0;
        end
    end

    // Frame configuration latched at the first accepted sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            fftpts_r  <= MIN_PTS_C;
            inverse_r <= 1'b0;
        end else if (latch_cfg_s) begin
            fftpts_r  <= cfg_points;
            inverse_r <= cfg_inverse;
        end
    end

    // Frames in flight: credited on sink eop, returned on source eop, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_r <= 3'd0;
        end else if (eop_hs_s & ~src_eop_s & (outstanding_r != 3'd7)) begin
            outstanding_r <= outstanding_r + 3'd1;
        end else if (~eop_hs_s & src_eop_s & (outstanding_r != 3'd0)) begin
            outstanding_r <= outstanding_r - 3'd1;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err_r  <= 1'b0;
            core_err_r <= 1'b0;
        end else begin
            cfg_err_r  <= cfg_bad_s | (cfg_err_r & ~err_clr);
            core_err_r <= (source_valid & (source_error != 2'b00)) | (core_err_r & ~err_clr);
        end
    end

    assign in_ready   = in_ready_s & ~reset;
    assign sink_valid = sink_valid_r;
    assign sink_sop   = sink_sop_r;
    assign sink_eop   = sink_eop_r;
    assign sink_real  = sink_real_r;
    assign sink_imag  = sink_imag_r;
    assign sink_error = 2'b00;
    assign fftpts_in  = fftpts_r;
    assign inverse    = inverse_r;
    assign busy       = (state_r != IDLE) | (outstanding_r != 3'd0);
    assign cfg_err    = cfg_err_r;
    assign core_err   = core_err_r;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: a frame-position model is checked every cycle,
// plus literal expectations (eop positions, sample counts, pad zeros, error flags).
module tb_fft_frame_ctrl;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [13:0] in_real = 14'd0, in_imag = 14'd0;
    logic [10:0] cfg_points = 11'd64;
    logic        cfg_inverse = 1'b0, err_clr = 1'b0, sink_ready = 1'b1;
    logic        source_valid = 1'b0, source_ready = 1'b0, source_eop = 1'b0;
    logic [1:0]  source_error = 2'b00;
    logic        in_ready, sink_valid, sink_sop, sink_eop, inverse, busy, cfg_err, core_err;
    logic [13:0] sink_real, sink_imag;
    logic [1:0]  sink_error;
    logic [10:0] fftpts_in;

    fft_frame_ctrl #(.MIN_PTS(64), .MAX_PTS(1024), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
        .cfg_points(cfg_points), .cfg_inverse(cfg_inverse), .err_clr(err_clr),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
        .sink_error(sink_error), .fftpts_in(fftpts_in), .inverse(inverse),
        .source_valid(source_valid), .source_ready(source_ready), .source_eop(source_eop),
        .source_error(source_error), .busy(busy), .cfg_err(cfg_err), .core_err(core_err)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    bit chk_en = 1'b0, ready_toggle = 1'b0;
    int cur_sent = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [13:0] pat_real(input int i);
        return 14'(i * 3 + 1);
    endfunction
    function automatic logic [13:0] pat_imag(input int i);
        return 14'(8000 - i);
    endfunction
    function automatic bit legal(input logic [10:0] p);
        int v;
        v = int'(p);
        return (v >= 64) && (v <= 1024) && ((v & (v - 1)) == 0);
    endfunction

    // Model: frame position (0 = no frame open), padding flag, sink slot, credits, errors.
    bit          m_valid = 0, m_sop = 0, m_eop = 0, m_pad = 0, m_inv = 0, m_cfg_err = 0, m_core_err = 0;
    logic [13:0] m_real = 14'd0, m_imag = 14'd0;
    logic [10:0] m_pts = 11'd64;
    int          m_pos = 0, m_out = 0;
    // Monitor tallies (written only by the compare process).
    int hs_count = 0, sop_count = 0, eop_count = 0, last_eop_idx = -1, mon_idx = 0;
    int data_bad = 0, nonzero_pad = 0;
    // Compare-process scratch.
    bit e_rdy, e_slot, e_ok, e_acc, e_emit, e_inc, e_dec, e_cset, e_kset;
    int e_idx, w_idx;
    logic [13:0] e_r, e_i;

    always @(negedge clk) begin
        if (chk_en) begin
            check("sink_valid", 32'(sink_valid), 32'(m_valid));
            if (m_valid) begin
                check("sink_sop", 32'(sink_sop), 32'(m_sop));
                check("sink_eop", 32'(sink_eop), 32'(m_eop));
                check("sink_real", 32'(sink_real), 32'(m_real));
                check("sink_imag", 32'(sink_imag), 32'(m_imag));
            end
            check("fftpts_in", 32'(fftpts_in), 32'(m_pts));
            check("inverse", 32'(inverse), 32'(m_inv));
            check("busy", 32'(busy), 32'((m_pos != 0) || (m_out != 0)));
            check("cfg_err", 32'(cfg_err), 32'(m_cfg_err));
            check("core_err", 32'(core_err), 32'(m_core_err));
            check("sink_error", 32'(sink_error), 32'd0);
        end
        e_slot = !m_valid || sink_ready;
        e_ok   = legal(cfg_points);
        if (reset)           e_rdy = 1'b0;
        else if (m_pos == 0) e_rdy = e_slot && e_ok && (m_out < MAXO);
        else if (m_pad)      e_rdy = 1'b0;
        else                 e_rdy = e_slot;
        if (chk_en) check("in_ready", 32'(in_ready), 32'(e_rdy));
        // Observe sink handshakes for the literal expectations.
        if (sink_valid === 1'b1 && sink_ready) begin
            w_idx = sink_sop ? 0 : mon_idx;
            hs_count++;
            if (sink_sop) sop_count++;
            if (w_idx < cur_sent) begin
                if (sink_real !== pat_real(w_idx) || sink_imag !== pat_imag(w_idx)) data_bad++;
            end else if (sink_real !== 14'd0 || sink_imag !== 14'd0) begin
                nonzero_pad++;
            end
            if (sink_eop) begin
                last_eop_idx = w_idx;
                eop_count++;
            end
            mon_idx = w_idx + 1;
        end
        // Advance the model across the coming rising edge.
        if (reset) begin
            m_valid = 0; m_sop = 0; m_eop = 0; m_pad = 0; m_inv = 0; m_pts = 11'd64;
            m_pos = 0; m_out = 0; m_cfg_err = 0; m_core_err = 0; m_real = 14'd0; m_imag = 14'd0;
        end else begin
            e_inc  = m_valid && sink_ready && m_eop;
            e_dec  = source_valid && source_ready && source_eop;
            e_acc  = in_valid && e_rdy;
            e_emit = 1'b0;
            e_cset = 1'b0;
            e_idx  = 0;
            e_r    = 14'd0;
            e_i    = 14'd0;
            if (m_pos == 0) begin
                if (in_valid && !e_ok) e_cset = 1'b1;
                if (e_acc) begin
                    m_pts = cfg_points; m_inv = cfg_inverse;
                    e_emit = 1'b1; e_r = in_real; e_i = in_imag; e_idx = 0; m_pad = in_last;
                end
            end else if (!m_pad) begin
                if (e_acc) begin
                    e_emit = 1'b1; e_r = in_real; e_i = in_imag; e_idx = m_pos;
                    if (in_last) m_pad = 1'b1;
                end
            end else if (e_slot) begin
                e_emit = 1'b1; e_idx = m_pos;
            end
            if (e_emit) begin
                m_valid = 1'b1;
                m_sop   = (e_idx == 0);
                m_eop   = (e_idx == int'(m_pts) - 1);
                m_real  = e_r;
                m_imag  = e_i;
                if (m_eop) begin m_pos = 0; m_pad = 1'b0; end
                else m_pos = e_idx + 1;
            end else if (sink_ready) begin
                m_valid = 1'b0;
            end
            if (e_inc && !e_dec) m_out = m_out + 1;
            else if (e_dec && !e_inc && m_out > 0) m_out = m_out - 1;
            e_kset = source_valid && (source_error != 2'b00);
            m_cfg_err  = e_cset ? 1'b1 : (err_clr ? 1'b0 : m_cfg_err);
            m_core_err = e_kset ? 1'b1 : (err_clr ? 1'b0 : m_core_err);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_toggle) sink_ready = ~sink_ready;
            else sink_ready = 1'b1;
        end
    end

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int nsent, input int last_at, input logic [10:0] pts, input logic inv);
        bit acc;
        int t;
        cur_sent = nsent; cfg_points = pts; cfg_inverse = inv;
        for (int i = 0; i < nsent; i++) begin
            in_valid = 1'b1; in_real = pat_real(i); in_imag = pat_imag(i); in_last = (i == last_at);
            acc = 1'b0; t = 0;
            while (!acc && t < 200) begin
                @(negedge clk); acc = in_ready; t++;
                next_cycle();
            end
            if (!acc) begin
                check("accept_timeout", 32'(acc), 32'd1);
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int t;
        t = 0;
        while (hs_count < target && t < 3000) begin
            @(negedge clk); #1; t++;
        end
        check("handshake_count", 32'(hs_count), 32'(target));
        next_cycle();
    endtask

    task automatic src_eop_pulse();
        source_valid = 1'b1; source_ready = 1'b1; source_eop = 1'b1;
        next_cycle();
        source_valid = 1'b0; source_ready = 1'b0; source_eop = 1'b0;
    endtask

    int b_hs, b_sop, b_bad, b_pad;

    task automatic snap();
        b_hs = hs_count; b_sop = sop_count; b_bad = data_bad; b_pad = nonzero_pad;
    endtask

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk); #1;
        check("rst_fftpts", 32'(fftpts_in), 32'd64);
        check("rst_sink_valid", 32'(sink_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // 64-point forward frame, contiguous samples.
        snap();
        send_frame(64, -1, 11'd64, 1'b0);
        wait_hs(b_hs + 64);
        check("t1_eop_idx", 32'(last_eop_idx), 32'd63);
        check("t1_sop_count", 32'(sop_count - b_sop), 32'd1);
        check("t1_fftpts", 32'(fftpts_in), 32'd64);
        check("t1_inverse", 32'(inverse), 32'd0);
        check("t1_data", 32'(data_bad - b_bad), 32'd0);
        src_eop_pulse();

        // 256-point inverse frame, in_last on sample 99, remainder padded.
        snap();
        send_frame(100, 99, 11'd256, 1'b1);
        @(negedge clk); #1;
        check("t2_pad_in_ready", 32'(in_ready), 32'd0);
        next_cycle();
        wait_hs(b_hs + 256);
        check("t2_eop_idx", 32'(last_eop_idx), 32'd255);
        check("t2_pad_zero", 32'(nonzero_pad - b_pad), 32'd0);
        check("t2_data", 32'(data_bad - b_bad), 32'd0);
        check("t2_fftpts", 32'(fftpts_in), 32'd256);
        check("t2_inverse", 32'(inverse), 32'd1);
        src_eop_pulse();

        // Alternating sink backpressure.
        snap();
        ready_toggle = 1'b1;
        send_frame(64, -1, 11'd64, 1'b0);
        wait_hs(b_hs + 64);
        ready_toggle = 1'b0;
        check("t3_eop_idx", 32'(last_eop_idx), 32'd63);
        check("t3_data", 32'(data_bad - b_bad), 32'd0);
        src_eop_pulse();

        // Two frames in flight with the source idle block a third.
        snap();
        send_frame(64, -1, 11'd64, 1'b0);
        send_frame(64, -1, 11'd64, 1'b0);
        wait_hs(b_hs + 128);
        repeat (2) next_cycle();
        in_valid = 1'b1; in_real = pat_real(0); in_imag = pat_imag(0); cfg_points = 11'd64;
        repeat (4) next_cycle();
        @(negedge clk); #1;
        check("t4_blocked_in_ready", 32'(in_ready), 32'd0);
        check("t4_blocked_hs", 32'(hs_count - b_hs), 32'd128);
        check("t4_busy", 32'(busy), 32'd1);
        next_cycle();
        in_valid = 1'b0;
        src_eop_pulse();
        snap();
        send_frame(64, -1, 11'd64, 1'b0);
        wait_hs(b_hs + 64);
        check("t4_third_eop_idx", 32'(last_eop_idx), 32'd63);
        repeat (3) src_eop_pulse();
        @(negedge clk); #1;
        check("t4_idle_busy", 32'(busy), 32'd0);
        next_cycle();

        // Illegal frame lengths (100, 2048 which wraps to 0 on 11 bits, 32).
        cfg_points = 11'd100; in_valid = 1'b1;
        @(negedge clk); #1;
        check("t5_cfg100_in_ready", 32'(in_ready), 32'd0);
        next_cycle();
        @(negedge clk); #1;
        check("t5_cfg_err", 32'(cfg_err), 32'd1);
        next_cycle();
        cfg_points = 11'd0; err_clr = 1'b1;
        next_cycle();
        @(negedge clk); #1;
        check("t5_set_wins", 32'(cfg_err), 32'd1);
        next_cycle();
        cfg_points = 11'd32; err_clr = 1'b0;
        next_cycle();
        in_valid = 1'b0; err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        @(negedge clk); #1;
        check("t5_cleared", 32'(cfg_err), 32'd0);
        next_cycle();
        snap();
        send_frame(128, -1, 11'd128, 1'b0);
        wait_hs(b_hs + 128);
        check("t5_eop_idx", 32'(last_eop_idx), 32'd127);
        src_eop_pulse();

        // Core error flag.
        source_valid = 1'b1; source_error = 2'b01;
        next_cycle();
        source_valid = 1'b0; source_error = 2'b00;
        @(negedge clk); #1;
        check("t6_core_err", 32'(core_err), 32'd1);
        next_cycle();
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        @(negedge clk); #1;
        check("t6_core_err_clr", 32'(core_err), 32'd0);
        next_cycle();

        // Reset in the middle of a frame.
        send_frame(30, -1, 11'd256, 1'b1);
        reset = 1'b1;
        next_cycle();
        @(negedge clk); #1;
        check("t7_sink_valid", 32'(sink_valid), 32'd0);
        check("t7_sink_sop", 32'(sink_sop), 32'd0);
        check("t7_sink_real", 32'(sink_real), 32'd0);
        check("t7_fftpts", 32'(fftpts_in), 32'd64);
        check("t7_inverse", 32'(inverse), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_in_ready", 32'(in_ready), 32'd0);
        next_cycle();
        reset = 1'b0;
        repeat (3) next_cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
